// File: rtl/ps2_host_transmitter.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send and a device-clocked
// 11-bit frame with ACK check; drives the bus open-drain through output enables.
module ps2_host_transmitter #(
  parameter int unsigned INHIBIT_CYCLES = 12000,
  parameter int unsigned RTS_CYCLES     = 200,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  output logic       ps2_clock_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       nak,
  output logic       timeout
);

  localparam int unsigned MAX_IR   = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int unsigned CNT_MAX  = (MAX_IR > TIMEOUT_CYCLES) ? MAX_IR : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned FRAME_W  = 10;

  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RTS_LAST     = CNT_W'(RTS_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_SAT  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] STOP_IDX     = IDX_W'(FRAME_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_SEND,
    S_ACK,
    S_WAIT_RELEASE
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [7:0]         r_byte, w_byte_nxt;
  logic               r_parity, w_parity_nxt;
  logic               r_ack_ok, w_ack_ok_nxt;

  logic               r_clk_meta, r_clk_sync, r_clk_prev;
  logic               r_data_meta, r_data_sync;

  logic               r_tx_ready, w_tx_ready_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_clock_oe, w_clock_oe_nxt;
  logic               r_data_oe, w_data_oe_nxt;
  logic               r_done, w_done_nxt;
  logic               r_nak, w_nak_nxt;
  logic               r_timeout, w_timeout_nxt;

  logic               w_handshake;
  logic               w_fall;
  logic               w_bus_idle;
  logic               w_in_xfer;
  logic               w_timed_out;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [FRAME_W-1:0] w_frame;

  assign tx_ready     = r_tx_ready;
  assign busy         = r_busy;
  assign ps2_clock_oe = r_clock_oe;
  assign ps2_data_oe  = r_data_oe;
  assign done         = r_done;
  assign nak          = r_nak;
  assign timeout      = r_timeout;

  assign w_handshake = tx_valid & r_tx_ready;
  assign w_fall      = r_clk_prev & ~r_clk_sync;
  assign w_bus_idle  = r_clk_sync & r_data_sync;
  assign w_in_xfer   = (r_state == S_SEND) || (r_state == S_ACK) || (r_state == S_WAIT_RELEASE);
  assign w_timed_out = w_in_xfer && (r_cnt == TIMEOUT_LAST);
  assign w_cnt_inc   = (r_cnt == TIMEOUT_SAT) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_frame     = {1'b1, r_parity, r_byte};

  // Pin synchronisers; reset to the idle-high bus level so no false edge is seen.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_meta  <= 1'b1;
      r_clk_sync  <= 1'b1;
      r_clk_prev  <= 1'b1;
      r_data_meta <= 1'b1;
      r_data_sync <= 1'b1;
    end else begin
      r_clk_meta  <= ps2_clock;
      r_clk_sync  <= r_clk_meta;
      r_clk_prev  <= r_clk_sync;
      r_data_meta <= ps2_data;
      r_data_sync <= r_data_meta;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_byte     <= '0;
      r_parity   <= 1'b0;
      r_ack_ok   <= 1'b0;
      r_tx_ready <= 1'b1;
      r_busy     <= 1'b0;
      r_clock_oe <= 1'b0;
      r_data_oe  <= 1'b0;
      r_done     <= 1'b0;
      r_nak      <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_idx      <= w_idx_nxt;
      r_byte     <= w_byte_nxt;
      r_parity   <= w_parity_nxt;
      r_ack_ok   <= w_ack_ok_nxt;
      r_tx_ready <= w_tx_ready_nxt;
      r_busy     <= w_busy_nxt;
      r_clock_oe <= w_clock_oe_nxt;
      r_data_oe  <= w_data_oe_nxt;
      r_done     <= w_done_nxt;
      r_nak      <= w_nak_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  // Next-state logic; timeout wins over any bus event in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:         if (w_handshake) w_state_nxt = S_INHIBIT;
      S_INHIBIT:      if (r_cnt == INHIBIT_LAST) w_state_nxt = S_RTS;
      S_RTS:          if (r_cnt == RTS_LAST) w_state_nxt = S_SEND;
      S_SEND: begin
        if (w_timed_out)                       w_state_nxt = S_IDLE;
        else if (w_fall && (r_idx == STOP_IDX)) w_state_nxt = S_ACK;
      end
      S_ACK: begin
        if (w_timed_out)  w_state_nxt = S_IDLE;
        else if (w_fall)  w_state_nxt = S_WAIT_RELEASE;
      end
      S_WAIT_RELEASE: begin
        if (w_timed_out || w_bus_idle) w_state_nxt = S_IDLE;
      end
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    w_cnt_nxt      = r_cnt;
    w_idx_nxt      = r_idx;
    w_byte_nxt     = r_byte;
    w_parity_nxt   = r_parity;
    w_ack_ok_nxt   = r_ack_ok;
    w_clock_oe_nxt = 1'b0;
    w_data_oe_nxt  = r_data_oe;
    w_done_nxt     = 1'b0;
    w_nak_nxt      = 1'b0;
    w_timeout_nxt  = 1'b0;
    w_tx_ready_nxt = (w_state_nxt == S_IDLE);
    w_busy_nxt     = (w_state_nxt != S_IDLE);
    unique case (r_state)
      S_IDLE: begin
        w_data_oe_nxt = 1'b0;
        if (w_handshake) begin
          w_byte_nxt     = tx_data;
          w_parity_nxt   = ~^tx_data;
          w_cnt_nxt      = '0;
          w_clock_oe_nxt = 1'b1;
        end
      end
      S_INHIBIT: begin
        w_clock_oe_nxt = 1'b1;
        if (r_cnt == INHIBIT_LAST) begin
          w_cnt_nxt     = '0;
          w_data_oe_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_RTS: begin
        w_data_oe_nxt = 1'b1;
        if (r_cnt == RTS_LAST) begin
          w_cnt_nxt = '0;
          w_idx_nxt = '0;
        end else begin
          w_cnt_nxt      = r_cnt + CNT_W'(1);
          w_clock_oe_nxt = 1'b1;
        end
      end
      S_SEND: begin
        w_cnt_nxt = w_cnt_inc;
        if (w_timed_out) begin
          w_data_oe_nxt = 1'b0;
          w_timeout_nxt = 1'b1;
        end else if (w_fall) begin
          w_data_oe_nxt = ~w_frame[r_idx];
          w_idx_nxt     = r_idx + IDX_W'(1);
        end
      end
      S_ACK: begin
        w_cnt_nxt     = w_cnt_inc;
        w_data_oe_nxt = 1'b0;
        if (w_timed_out) w_timeout_nxt = 1'b1;
        else if (w_fall) w_ack_ok_nxt = ~r_data_sync;
      end
      S_WAIT_RELEASE: begin
        w_cnt_nxt     = w_cnt_inc;
        w_data_oe_nxt = 1'b0;
        if (w_timed_out) begin
          w_timeout_nxt = 1'b1;
        end else if (w_bus_idle) begin
          w_done_nxt = r_ack_ok;
          w_nak_nxt  = ~r_ack_ok;
        end
      end
      default: w_data_oe_nxt = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Directed bench for ps2_host_transmitter with a behavioural PS/2 device that
// clocks the frame at 40-cycle half periods and samples data on rising edges.
module tb_ps2_host_transmitter;

  localparam int unsigned INHIBIT = 20;
  localparam int unsigned RTS     = 4;
  // A full frame at 40-cycle half periods lasts ~900 cycles, so the limit must exceed it.
  localparam int unsigned TO      = 1200;
  localparam int unsigned HALF    = 40;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, busy, done, nak, timeout;
  logic       ps2_clock_oe, ps2_data_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clock, ps2_data;

  int checks = 0;
  int failures = 0;
  int n_done = 0;
  int n_nak = 0;
  int n_to = 0;

  assign ps2_clock = ~(ps2_clock_oe | dev_clk_low);
  assign ps2_data  = ~(ps2_data_oe | dev_data_low);

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (done === 1'b1)    n_done <= n_done + 1;
    if (nak === 1'b1)     n_nak  <= n_nak + 1;
    if (timeout === 1'b1) n_to   <= n_to + 1;
  end

  ps2_host_transmitter #(
    .INHIBIT_CYCLES(INHIBIT),
    .RTS_CYCLES(RTS),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_ready(tx_ready),
    .ps2_clock(ps2_clock),
    .ps2_data(ps2_data),
    .ps2_clock_oe(ps2_clock_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy(busy),
    .done(done),
    .nak(nak),
    .timeout(timeout)
  );

  // Device side: wait for clock release, then clock 10 bits plus the ACK pulse.
  task automatic dev_frame(input bit do_ack, output logic [10:0] frame, output bit ok);
    ok = 1'b0;
    frame = '0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clock);
      if (ps2_clock_oe === 1'b0 && busy === 1'b1) ok = 1'b1;
    end
    if (ok) begin
      repeat (HALF) @(negedge clock);
      frame[0] = ps2_data;
      for (int k = 1; k <= 10; k++) begin
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clock);
        dev_clk_low = 1'b0;
        frame[k] = ps2_data;
        repeat (HALF) @(negedge clock);
      end
      if (do_ack) dev_data_low = 1'b1;
      repeat (10) @(negedge clock);
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clock);
      dev_clk_low = 1'b0;
      repeat (20) @(negedge clock);
      dev_data_low = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if ({ps2_clock_oe, ps2_data_oe} !== 2'b00) begin failures++; $display("FAIL reset_oe got=%b exp=00", {ps2_clock_oe, ps2_data_oe}); end
    checks++; if ({done, nak, timeout} !== 3'b000) begin failures++; $display("FAIL reset_pulses got=%b exp=000", {done, nak, timeout}); end
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if ({tx_ready, busy} !== 2'b10) begin failures++; $display("FAIL idle_after_reset got=%b exp=10", {tx_ready, busy}); end
  endtask

  task automatic test_send_ed();
    logic [10:0] fr;
    bit ok;
    int d0, k0, t0;
    logic rdy_at_done;
    d0 = n_done; k0 = n_nak; t0 = n_to;
    tx_valid = 1'b1; tx_data = 8'hED;
    @(negedge clock);
    tx_valid = 1'b0;
    checks++; if ({tx_ready, busy, ps2_clock_oe, ps2_data_oe} !== 4'b0110) begin failures++; $display("FAIL ed_t1 got=%b exp=0110", {tx_ready, busy, ps2_clock_oe, ps2_data_oe}); end
    repeat (19) @(negedge clock);
    checks++; if (ps2_data_oe !== 1'b0) begin failures++; $display("FAIL ed_t20_data_oe got=%b exp=0", ps2_data_oe); end
    @(negedge clock);
    checks++; if ({ps2_clock_oe, ps2_data_oe} !== 2'b11) begin failures++; $display("FAIL ed_t21_oe got=%b exp=11", {ps2_clock_oe, ps2_data_oe}); end
    repeat (3) @(negedge clock);
    checks++; if (ps2_clock_oe !== 1'b1) begin failures++; $display("FAIL ed_t24_clock_oe got=%b exp=1", ps2_clock_oe); end
    @(negedge clock);
    checks++; if ({ps2_clock_oe, ps2_data_oe} !== 2'b01) begin failures++; $display("FAIL ed_t25_oe got=%b exp=01", {ps2_clock_oe, ps2_data_oe}); end
    dev_frame(1'b1, fr, ok);
    checks++; if (!ok) begin failures++; $display("FAIL ed_start_wait got=0 exp=1"); end
    // frame order: start, d0..d7 = 1,0,1,1,0,1,1,1, parity 1, stop 1
    checks++; if (fr !== 11'b11_1110_1101_0) begin failures++; $display("FAIL ed_frame got=%b exp=%b", fr, 11'b11111011010); end
    rdy_at_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (done === 1'b1) rdy_at_done = tx_ready;
    end
    checks++; if (n_done - d0 !== 1) begin failures++; $display("FAIL ed_done_count got=%0d exp=1", n_done - d0); end
    checks++; if ((n_nak - k0) + (n_to - t0) !== 0) begin failures++; $display("FAIL ed_other_pulses got=%0d exp=0", (n_nak - k0) + (n_to - t0)); end
    checks++; if (rdy_at_done !== 1'b1) begin failures++; $display("FAIL ed_ready_with_done got=%b exp=1", rdy_at_done); end
  endtask

  task automatic test_parity();
    logic [7:0]  bytes [3] = '{8'h00, 8'hFF, 8'h07};
    logic [10:0] exp   [3] = '{11'b11_0000_0000_0, 11'b11_1111_1111_0, 11'b10_0000_0111_0};
    logic [10:0] fr;
    bit ok;
    int d0;
    for (int i = 0; i < 3; i++) begin
      d0 = n_done;
      tx_valid = 1'b1; tx_data = bytes[i];
      @(negedge clock);
      tx_valid = 1'b0;
      dev_frame(1'b1, fr, ok);
      repeat (30) @(negedge clock);
      checks++; if (!ok || fr !== exp[i]) begin failures++; $display("FAIL parity_frame_%0d byte=%h got=%b exp=%b", i, bytes[i], fr, exp[i]); end
      checks++; if (n_done - d0 !== 1) begin failures++; $display("FAIL parity_done_%0d got=%0d exp=1", i, n_done - d0); end
    end
  endtask

  task automatic test_no_ack();
    logic [10:0] fr;
    bit ok;
    int d0, k0;
    d0 = n_done; k0 = n_nak;
    tx_valid = 1'b1; tx_data = 8'h55;
    @(negedge clock);
    tx_valid = 1'b0;
    dev_frame(1'b0, fr, ok);
    repeat (30) @(negedge clock);
    checks++; if (!ok || fr !== 11'b11_0101_0101_0) begin failures++; $display("FAIL noack_frame got=%b exp=%b", fr, 11'b11010101010); end
    checks++; if (n_nak - k0 !== 1) begin failures++; $display("FAIL noack_nak_count got=%0d exp=1", n_nak - k0); end
    checks++; if (n_done - d0 !== 0) begin failures++; $display("FAIL noack_done_count got=%0d exp=0", n_done - d0); end
    checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL noack_ready got=%b exp=1", tx_ready); end
  endtask

  task automatic test_timeout();
    int n, m, d0, k0;
    d0 = n_done; k0 = n_nak;
    tx_valid = 1'b1; tx_data = 8'h12;
    @(negedge clock);
    tx_valid = 1'b0;
    n = 1;
    while (ps2_clock_oe !== 1'b0 && n < 100) begin @(negedge clock); n++; end
    checks++; if (n != 25) begin failures++; $display("FAIL to_release_cycle got=%0d exp=25", n); end
    m = 0;
    while (timeout !== 1'b1 && m < int'(TO) + 50) begin @(negedge clock); m++; end
    checks++; if (m != int'(TO)) begin failures++; $display("FAIL to_latency got=%0d exp=%0d", m, TO); end
    checks++; if ({ps2_clock_oe, ps2_data_oe} !== 2'b00) begin failures++; $display("FAIL to_oe got=%b exp=00", {ps2_clock_oe, ps2_data_oe}); end
    checks++; if ({tx_ready, busy} !== 2'b10) begin failures++; $display("FAIL to_idle got=%b exp=10", {tx_ready, busy}); end
    repeat (5) @(negedge clock);
    checks++; if ((n_done - d0) + (n_nak - k0) !== 0 || timeout !== 1'b0) begin failures++; $display("FAIL to_single_pulse got=%0d/%b exp=0/0", (n_done - d0) + (n_nak - k0), timeout); end
  endtask

  task automatic test_back_to_back();
    logic [10:0] fr;
    bit ok;
    int d0;
    logic rdy_at_done;
    d0 = n_done;
    tx_valid = 1'b1; tx_data = 8'hA5;
    @(negedge clock);
    tx_data = 8'h3C;
    checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_busy got=%b exp=0", tx_ready); end
    dev_frame(1'b1, fr, ok);
    checks++; if (!ok || fr !== 11'b11_1010_0101_0) begin failures++; $display("FAIL b2b_first_frame got=%b exp=%b", fr, 11'b11101001010); end
    rdy_at_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (done === 1'b1) rdy_at_done = tx_ready;
    end
    tx_valid = 1'b0;
    checks++; if (n_done - d0 !== 1 || rdy_at_done !== 1'b1) begin failures++; $display("FAIL b2b_first_done got=%0d/%b exp=1/1", n_done - d0, rdy_at_done); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_second_accepted got=%b exp=1", busy); end
    dev_frame(1'b1, fr, ok);
    repeat (30) @(negedge clock);
    checks++; if (!ok || fr !== 11'b11_0011_1100_0) begin failures++; $display("FAIL b2b_second_frame got=%b exp=%b", fr, 11'b11001111000); end
    checks++; if (n_done - d0 !== 2 || busy !== 1'b0) begin failures++; $display("FAIL b2b_second_done got=%0d/%b exp=2/0", n_done - d0, busy); end
  endtask

  task automatic test_reset_mid();
    logic [10:0] fr;
    bit ok;
    int d0, k0, t0;
    tx_valid = 1'b1; tx_data = 8'hED;
    @(negedge clock);
    tx_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clock);
      if (ps2_clock_oe === 1'b0 && busy === 1'b1) ok = 1'b1;
    end
    checks++; if (!ok) begin failures++; $display("FAIL rst_start_wait got=0 exp=1"); end
    repeat (HALF) @(negedge clock);
    for (int k = 0; k < 4; k++) begin
      dev_clk_low = 1'b1; repeat (HALF) @(negedge clock);
      dev_clk_low = 1'b0; repeat (HALF) @(negedge clock);
    end
    dev_clk_low = 1'b1;
    repeat (10) @(negedge clock);
    checks++; if (ps2_data_oe !== 1'b1) begin failures++; $display("FAIL rst_bit4_driven got=%b exp=1", ps2_data_oe); end
    d0 = n_done; k0 = n_nak; t0 = n_to;
    reset_n = 1'b0;
    #1;
    checks++; if ({ps2_clock_oe, ps2_data_oe} !== 2'b00) begin failures++; $display("FAIL rst_async_release got=%b exp=00", {ps2_clock_oe, ps2_data_oe}); end
    @(negedge clock);
    dev_clk_low = 1'b0;
    repeat (4) @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    checks++; if ((n_done - d0) + (n_nak - k0) + (n_to - t0) !== 0) begin failures++; $display("FAIL rst_no_pulse got=%0d exp=0", (n_done - d0) + (n_nak - k0) + (n_to - t0)); end
    checks++; if ({tx_ready, busy} !== 2'b10) begin failures++; $display("FAIL rst_idle got=%b exp=10", {tx_ready, busy}); end
    d0 = n_done;
    tx_valid = 1'b1; tx_data = 8'hFF;
    @(negedge clock);
    tx_valid = 1'b0;
    dev_frame(1'b1, fr, ok);
    repeat (30) @(negedge clock);
    checks++; if (!ok || fr !== 11'b11_1111_1111_0) begin failures++; $display("FAIL rst_ff_frame got=%b exp=%b", fr, 11'b11111111110); end
    checks++; if (n_done - d0 !== 1) begin failures++; $display("FAIL rst_ff_done got=%0d exp=1", n_done - d0); end
  endtask

  initial begin
    test_reset();
    test_send_ed();
    test_parity();
    test_no_ack();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
